// File: rtl/ram_sp_fifo_ctrl.sv
// rtl/ram_sp_fifo_ctrl.sv - FIFO controller over a single-port SRAM with a 2-entry output buffer
module ram_sp_fifo_ctrl #(
  parameter int ADR_WD = 10,
  parameter int DAT_WD = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr_i,
  input  logic              push_vld_i,
  output logic              push_rdy_o,
  input  logic [DAT_WD-1:0] push_dat_i,
  output logic              pop_vld_o,
  input  logic              pop_rdy_i,
  output logic [DAT_WD-1:0] pop_dat_o,
  output logic [ADR_WD:0]   cnt_o,
  output logic [ADR_WD-1:0] adr_o,
  output logic              wr_ena_o,
  output logic [DAT_WD-1:0] wr_dat_o,
  output logic              rd_ena_o,
  input  logic [DAT_WD-1:0] rd_dat_i
);

  localparam logic [ADR_WD:0] DEPTH = {1'b1, {ADR_WD{1'b0}}};

  logic [ADR_WD-1:0] wr_ptr;
  logic [ADR_WD-1:0] rd_ptr;
  logic [ADR_WD:0]   mem_cnt;
  logic [ADR_WD:0]   cnt_q;
  logic [DAT_WD-1:0] obuf_q [2];
  logic              obuf_hd;
  logic [1:0]        obuf_cnt;
  logic              rd_inflt;
  logic              prio;
  logic              init;

  logic mem_empty;
  logic mem_full;
  logic rd_want;
  logic wr_want;
  logic rd_grant;
  logic wr_grant;
  logic pop_fire;
  logic obuf_tl;

  assign mem_empty = (mem_cnt == '0);
  assign mem_full  = (mem_cnt == DEPTH);

  // obuf space is reserved at issue time, so in-flight reads count as occupied
  assign rd_want = !mem_empty && (({1'b0, obuf_cnt} + {2'b00, rd_inflt}) < 3'd2);
  assign wr_want = push_vld_i && !mem_full && init;

  // Ready assumes a competing write request, so it never looks at push_vld_i
  assign push_rdy_o = init && !mem_full && !clr_i && !(rd_want && !prio);
  assign wr_grant   = push_vld_i && push_rdy_o;
  assign rd_grant   = !clr_i && rd_want && !wr_grant;

  assign pop_vld_o = (obuf_cnt != 2'd0);
  assign pop_dat_o = obuf_q[obuf_hd];
  assign pop_fire  = pop_vld_o && pop_rdy_i;
  assign obuf_tl   = obuf_hd ^ obuf_cnt[0];

  assign wr_ena_o = wr_grant;
  assign rd_ena_o = rd_grant;
  assign adr_o    = wr_grant ? wr_ptr : (rd_grant ? rd_ptr : '0);
  assign wr_dat_o = init ? push_dat_i : '0;
  assign cnt_o    = cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      cnt_q     <= '0;
      obuf_q[0] <= '0;
      obuf_q[1] <= '0;
      obuf_hd   <= 1'b0;
      obuf_cnt  <= 2'd0;
      rd_inflt  <= 1'b0;
      prio      <= 1'b0;
      init      <= 1'b0;
    end else begin
      init <= 1'b1;
      if (clr_i) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        mem_cnt  <= '0;
        cnt_q    <= '0;
        obuf_hd  <= 1'b0;
        obuf_cnt <= 2'd0;
        rd_inflt <= 1'b0;
        prio     <= 1'b0;
      end else begin
        if (wr_grant) begin
          wr_ptr  <= wr_ptr + ADR_WD'(1);
          mem_cnt <= mem_cnt + (ADR_WD+1)'(1);
        end else if (rd_grant) begin
          rd_ptr  <= rd_ptr + ADR_WD'(1);
          mem_cnt <= mem_cnt - (ADR_WD+1)'(1);
        end
        rd_inflt <= rd_grant;
        if (rd_want && wr_want) prio <= !prio;
        if (rd_inflt) obuf_q[obuf_tl] <= rd_dat_i;
        obuf_hd  <= obuf_hd ^ pop_fire;
        obuf_cnt <= obuf_cnt + {1'b0, rd_inflt} - {1'b0, pop_fire};
        // Transfers between SRAM, in-flight slot and obuf keep the total unchanged
        cnt_q    <= cnt_q + {{ADR_WD{1'b0}}, wr_grant} - {{ADR_WD{1'b0}}, pop_fire};
      end
    end
  end

endmodule

// File: tb/tb_ram_sp_fifo_ctrl.sv
// tb/tb_ram_sp_fifo_ctrl.sv - randomized queue-model bench for ram_sp_fifo_ctrl
module tb_ram_sp_fifo_ctrl;
  localparam int ADR_WD = 10;
  localparam int DAT_WD = 32;
  localparam int DEPTH  = 1 << ADR_WD;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              clr_i = 1'b0;
  logic              push_vld_i = 1'b0;
  logic              push_rdy_o;
  logic [DAT_WD-1:0] push_dat_i = '0;
  logic              pop_vld_o;
  logic              pop_rdy_i = 1'b0;
  logic [DAT_WD-1:0] pop_dat_o;
  logic [ADR_WD:0]   cnt_o;
  logic [ADR_WD-1:0] adr_o;
  logic              wr_ena_o;
  logic [DAT_WD-1:0] wr_dat_o;
  logic              rd_ena_o;
  logic [DAT_WD-1:0] rd_dat_i = '0;

  ram_sp_fifo_ctrl #(.ADR_WD(ADR_WD), .DAT_WD(DAT_WD)) dut (
    .clk(clk), .rstn(rstn), .clr_i(clr_i),
    .push_vld_i(push_vld_i), .push_rdy_o(push_rdy_o), .push_dat_i(push_dat_i),
    .pop_vld_o(pop_vld_o), .pop_rdy_i(pop_rdy_i), .pop_dat_o(pop_dat_o),
    .cnt_o(cnt_o), .adr_o(adr_o), .wr_ena_o(wr_ena_o), .wr_dat_o(wr_dat_o),
    .rd_ena_o(rd_ena_o), .rd_dat_i(rd_dat_i)
  );

  always #5 clk = ~clk;

  // Single-port SRAM beside the controller; idle cycles return junk
  logic [DAT_WD-1:0] sram [DEPTH];
  always @(posedge clk) begin
    if (wr_ena_o) sram[adr_o] <= wr_dat_o;
    if (rd_ena_o) rd_dat_i <= sram[adr_o];
    else          rd_dat_i <= $urandom;
  end

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_popped = 0;
  logic [DAT_WD-1:0] exp_q [$];
  logic push_fire_s = 1'b0;
  logic pop_fire_s = 1'b0;
  logic clr_s = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: an ideal FIFO of accepted words
  always @(negedge clk) begin
    push_fire_s <= rstn && push_vld_i && push_rdy_o;
    pop_fire_s  <= rstn && pop_vld_o && pop_rdy_i;
    clr_s       <= rstn && clr_i;
    if (rstn) begin
      n_chk++;
      if (cnt_o !== (ADR_WD+1)'(exp_q.size()))
        $display("FAIL cnt_o got %0d exp %0d at cycle %0d", cnt_o, exp_q.size(), cyc);
      else n_pass++;
      n_chk++;
      if ((wr_ena_o & rd_ena_o) !== 1'b0)
        $display("FAIL sram_excl got wr=%b rd=%b exp not both", wr_ena_o, rd_ena_o);
      else n_pass++;
      if (pop_vld_o && pop_rdy_i && !clr_i) begin
        n_chk++;
        if (exp_q.size() == 0)
          $display("FAIL pop_data got %h exp nothing (model empty)", pop_dat_o);
        else if (pop_dat_o !== exp_q[0])
          $display("FAIL pop_data got %h exp %h", pop_dat_o, exp_q[0]);
        else n_pass++;
      end
      if (wr_ena_o) begin
        n_chk++;
        if (wr_dat_o !== push_dat_i)
          $display("FAIL wr_dat got %h exp %h", wr_dat_o, push_dat_i);
        else n_pass++;
      end
    end
  end

  always @(posedge clk) begin
    if (rstn) begin
      if (clr_s) exp_q.delete();
      else begin
        if (pop_fire_s && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          n_popped++;
        end
        if (push_fire_s) exp_q.push_back(push_dat_i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    push_vld_i = 1'b1;
    pop_rdy_i = 1'b1;
    push_dat_i = 32'hDEAD_BEEF;
    exp_q.delete();
    repeat (2) tick();
    @(negedge clk);
    n_chk++;
    if ({push_rdy_o, pop_vld_o, pop_dat_o, cnt_o, adr_o, wr_ena_o, wr_dat_o, rd_ena_o} !== '0)
      $display("FAIL reset_outputs got rdy=%b vld=%b dat=%h cnt=%0d adr=%0d we=%b wd=%h re=%b exp all 0",
               push_rdy_o, pop_vld_o, pop_dat_o, cnt_o, adr_o, wr_ena_o, wr_dat_o, rd_ena_o);
    else n_pass++;
    push_vld_i = 1'b0;
    pop_rdy_i = 1'b0;
    push_dat_i = '0;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    n_chk++;
    if (push_rdy_o !== 1'b0) $display("FAIL init_rdy0 got %b exp 0", push_rdy_o);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (push_rdy_o !== 1'b1) $display("FAIL init_rdy1 got %b exp 1", push_rdy_o);
    else n_pass++;
    tick();
  endtask

  task automatic test_order();
    int acc = 0;
    int idx = 0;
    int first_push = -1;
    int first_vld = -1;
    int base = n_popped;
    push_vld_i = 1'b1;
    push_dat_i = 0;
    pop_rdy_i = 1'b1;
    for (int c = 0; c < 200 && (n_popped - base) < 10; c++) begin
      @(negedge clk);
      if (first_vld < 0 && pop_vld_o) first_vld = cyc;
      if (pop_vld_o && pop_rdy_i) begin
        n_chk++;
        if (pop_dat_o !== DAT_WD'(idx)) $display("FAIL order_data got %h exp %h", pop_dat_o, idx);
        else n_pass++;
        idx++;
      end
      if (push_vld_i && push_rdy_o) begin
        if (first_push < 0) first_push = cyc;
        acc++;
      end
      tick();
      push_dat_i = DAT_WD'(acc);
      push_vld_i = (acc < 10);
    end
    push_vld_i = 1'b0;
    n_chk++;
    if (n_popped - base !== 10) $display("FAIL order_count got %0d exp 10", n_popped - base);
    else n_pass++;
    n_chk++;
    if (first_vld - first_push !== 3) $display("FAIL first_latency got %0d exp 3", first_vld - first_push);
    else n_pass++;
  endtask

  task automatic test_full();
    int acc = 0;
    int stall = 0;
    int base = n_popped;
    pop_rdy_i = 1'b0;
    push_vld_i = 1'b1;
    push_dat_i = $urandom;
    for (int c = 0; c < 4000 && stall < 8; c++) begin
      @(negedge clk);
      if (push_vld_i && push_rdy_o) begin
        acc++;
        stall = 0;
      end else stall++;
      tick();
      push_dat_i = $urandom;
    end
    n_chk++;
    if (acc !== DEPTH + 2) $display("FAIL full_accepted got %0d exp %0d", acc, DEPTH + 2);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (cnt_o !== 11'd1026) $display("FAIL full_cnt got %0d exp 1026", cnt_o);
    else n_pass++;
    n_chk++;
    if (push_rdy_o !== 1'b0) $display("FAIL full_rdy got %b exp 0", push_rdy_o);
    else n_pass++;
    tick();
    push_vld_i = 1'b0;
    pop_rdy_i = 1'b1;
    for (int c = 0; c < 5000 && (n_popped - base) < DEPTH + 2; c++) tick();
    pop_rdy_i = 1'b0;
    @(negedge clk);
    n_chk++;
    if (n_popped - base !== DEPTH + 2) $display("FAIL drain_count got %0d exp %0d", n_popped - base, DEPTH + 2);
    else n_pass++;
    n_chk++;
    if ({cnt_o, pop_vld_o} !== '0) $display("FAIL drain_empty got cnt=%0d vld=%b exp 0/0", cnt_o, pop_vld_o);
    else n_pass++;
    tick();
  endtask

  task automatic test_alternate();
    int acc = 0;
    logic prev_rd = 1'b0;
    pop_rdy_i = 1'b0;
    push_vld_i = 1'b1;
    push_dat_i = $urandom;
    for (int c = 0; c < 2000 && acc < DEPTH / 2; c++) begin
      @(negedge clk);
      if (push_vld_i && push_rdy_o) acc++;
      tick();
      push_dat_i = $urandom;
      push_vld_i = (acc < DEPTH / 2);
    end
    push_vld_i = 1'b1;
    pop_rdy_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c >= 4) begin
        n_chk++;
        if ((wr_ena_o ^ rd_ena_o) !== 1'b1 || rd_ena_o === prev_rd)
          $display("FAIL alternate got wr=%b rd=%b prev_rd=%b exp toggling grant", wr_ena_o, rd_ena_o, prev_rd);
        else n_pass++;
      end
      prev_rd = rd_ena_o;
      tick();
      push_dat_i = $urandom;
    end
    push_vld_i = 1'b0;
    for (int c = 0; c < 3000 && exp_q.size() > 0; c++) tick();
    n_chk++;
    if (exp_q.size() !== 0) $display("FAIL alt_drain got %0d left exp 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_stream();
    int acc = 0;
    int base = n_popped;
    for (int c = 0; c < 40000 && (n_popped - base) < 3000; c++) begin
      push_vld_i = (acc < 3000) && ($urandom_range(0, 3) != 0);
      pop_rdy_i = ($urandom_range(0, 3) != 0);
      push_dat_i = $urandom;
      @(negedge clk);
      if (push_vld_i && push_rdy_o) acc++;
      tick();
    end
    push_vld_i = 1'b0;
    pop_rdy_i = 1'b0;
    n_chk++;
    if (n_popped - base !== 3000) $display("FAIL stream_count got %0d exp 3000", n_popped - base);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (cnt_o !== '0) $display("FAIL stream_cnt got %0d exp 0", cnt_o);
    else n_pass++;
    tick();
  endtask

  task automatic test_clear();
    logic found = 1'b0;
    logic pushed = 1'b0;
    logic got_vld = 1'b0;
    logic [DAT_WD-1:0] got = '0;
    pop_rdy_i = 1'b0;
    push_vld_i = 1'b1;
    push_dat_i = 32'h1234_5678;
    for (int c = 0; c < 10 && !pushed; c++) begin
      @(negedge clk);
      if (push_rdy_o) pushed = 1'b1;
      tick();
    end
    push_vld_i = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (rd_ena_o) found = 1'b1;
      tick();
    end
    n_chk++;
    if (found !== 1'b1) $display("FAIL clr_read_seen got %b exp 1", found);
    else n_pass++;
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_chk++;
      if ({pop_vld_o, cnt_o} !== '0) $display("FAIL clr_empty got vld=%b cnt=%0d exp 0/0", pop_vld_o, cnt_o);
      else n_pass++;
      tick();
    end
    pushed = 1'b0;
    push_vld_i = 1'b1;
    push_dat_i = 32'hA5;
    pop_rdy_i = 1'b1;
    for (int c = 0; c < 20 && !got_vld; c++) begin
      @(negedge clk);
      if (push_vld_i && push_rdy_o) pushed = 1'b1;
      if (pop_vld_o) begin
        got_vld = 1'b1;
        got = pop_dat_o;
      end
      tick();
      if (pushed) push_vld_i = 1'b0;
    end
    pop_rdy_i = 1'b0;
    n_chk++;
    if (got_vld !== 1'b1 || got !== 32'hA5) $display("FAIL clr_after_push got vld=%b dat=%h exp 1/a5", got_vld, got);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic got_vld = 1'b0;
    logic [DAT_WD-1:0] got = '0;
    push_vld_i = 1'b1;
    pop_rdy_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      push_dat_i = $urandom | 32'h1;
      tick();
    end
    @(posedge clk);
    #3;
    rstn = 1'b0;
    exp_q.delete();
    #1;
    n_chk++;
    if ({push_rdy_o, pop_vld_o, pop_dat_o, cnt_o, adr_o, wr_ena_o, wr_dat_o, rd_ena_o} !== '0)
      $display("FAIL async_reset_out got rdy=%b vld=%b dat=%h cnt=%0d adr=%0d we=%b wd=%h re=%b exp all 0",
               push_rdy_o, pop_vld_o, pop_dat_o, cnt_o, adr_o, wr_ena_o, wr_dat_o, rd_ena_o);
    else n_pass++;
    push_vld_i = 1'b0;
    pop_rdy_i = 1'b0;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    n_chk++;
    if (push_rdy_o !== 1'b0) $display("FAIL rerst_rdy0 got %b exp 0", push_rdy_o);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({push_rdy_o, pop_vld_o, cnt_o} !== {1'b1, 1'b0, 11'd0})
      $display("FAIL rerst_empty got rdy=%b vld=%b cnt=%0d exp 1/0/0", push_rdy_o, pop_vld_o, cnt_o);
    else n_pass++;
    tick();
    push_vld_i = 1'b1;
    push_dat_i = 32'h5A5A_0001;
    pop_rdy_i = 1'b1;
    for (int c = 0; c < 20 && !got_vld; c++) begin
      @(negedge clk);
      if (pop_vld_o) begin
        got_vld = 1'b1;
        got = pop_dat_o;
      end
      tick();
      push_vld_i = 1'b0;
    end
    pop_rdy_i = 1'b0;
    n_chk++;
    if (got_vld !== 1'b1 || got !== 32'h5A5A_0001) $display("FAIL rerst_push got vld=%b dat=%h exp 1/5a5a0001", got_vld, got);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_order();
    test_full();
    test_alternate();
    test_stream();
    test_clear();
    test_async_reset();
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
